// File: rtl/spm_responder.sv
// ---------------------------------------------------------------------------------------------
// spm_responder
//
// Scratch-pad memory responder: slave end of the NI SPM bus. Storage is SPM_WORDS x 64 bit,
// kept as two 32-bit halves with independent write enables. Two access ports share it:
//   - NoC port: 64-bit word address, per-half enables, registered 64-bit response.
//   - Processor port: 32-bit word address (bit 0 selects the half), registered 32-bit response.
// Every access completes in exactly one cycle; the response registers are the only pipeline
// stage. There is no back-pressure and no state machine.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset (clears responses, not the memory)
//   spm_addr       NoC 64-bit word address
//   spm_en         NoC half enables: [1] = bits 63:32, [0] = bits 31:0
//   spm_wr         NoC write (1) / read (0)
//   spm_wdata      NoC write data
//   spm_slv_rdata  NoC read data (registered)
//   spm_slv_error  NoC range / error pulse (registered)
//   p_addr         processor 32-bit word address: [0] = half, [ADDR_W:1] = 64-bit word
//   p_en           processor access valid
//   p_wr           processor write (1) / read (0)
//   p_wdata        processor write data
//   p_rdata        processor read data (registered)
//   p_error        processor error pulse (registered)
// ---------------------------------------------------------------------------------------------
module spm_responder #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned SPM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    // NoC-side port
    input  logic [ADDR_W-1:0] spm_addr,
    input  logic [1:0]        spm_en,
    input  logic              spm_wr,
    input  logic [63:0]       spm_wdata,
    output logic [63:0]       spm_slv_rdata,
    output logic              spm_slv_error,
    // Processor-side port
    input  logic [ADDR_W:0]   p_addr,
    input  logic              p_en,
    input  logic              p_wr,
    input  logic [31:0]       p_wdata,
    output logic [31:0]       p_rdata,
    output logic              p_error
);

    localparam int unsigned IdxW = (SPM_WORDS > 1) ? $clog2(SPM_WORDS) : 1;
    // One extra bit so SPM_WORDS == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] WordLimit = (ADDR_W + 1)'(SPM_WORDS);

    // -----------------------------------------------------------------------------------------
    // Storage: two 32-bit halves, never reset
    // -----------------------------------------------------------------------------------------
    logic [31:0] mem_lo [SPM_WORDS];
    logic [31:0] mem_hi [SPM_WORDS];

    // -----------------------------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------------------------
    logic              noc_acc;
    logic              noc_oor;
    logic [IdxW-1:0]   noc_idx;

    logic [ADDR_W-1:0] p_word;
    logic              p_half;
    logic              p_oor;
    logic [IdxW-1:0]   p_idx;

    assign noc_acc = |spm_en;
    assign noc_oor = {1'b0, spm_addr} >= WordLimit;
    assign noc_idx = spm_addr[IdxW-1:0];

    assign p_word  = p_addr[ADDR_W:1];
    assign p_half  = p_addr[0];
    assign p_oor   = {1'b0, p_word} >= WordLimit;
    assign p_idx   = p_word[IdxW-1:0];

    // -----------------------------------------------------------------------------------------
    // Write enables and port collision
    // -----------------------------------------------------------------------------------------
    logic noc_we;
    logic noc_we_lo;
    logic noc_we_hi;
    logic p_collide;
    logic p_we;

    assign noc_we    = !reset && noc_acc && spm_wr && !noc_oor;
    assign noc_we_lo = noc_we && spm_en[0];
    assign noc_we_hi = noc_we && spm_en[1];

    // Both ports writing the same half of the same word: the NoC write wins and the
    // processor write is dropped (reported as a processor error).
    assign p_collide = noc_we && spm_en[p_half] && (spm_addr == p_word)
                       && p_en && p_wr && !p_oor;

    assign p_we      = !reset && p_en && p_wr && !p_oor && !p_collide;

    // Non-blocking writes give read-before-write for a read on the other port in the same cycle.
    always_ff @(posedge clk) begin
        if (noc_we_lo) begin
            mem_lo[noc_idx] <= spm_wdata[31:0];
        end
        if (noc_we_hi) begin
            mem_hi[noc_idx] <= spm_wdata[63:32];
        end
        if (p_we && !p_half) begin
            mem_lo[p_idx] <= p_wdata;
        end
        if (p_we && p_half) begin
            mem_hi[p_idx] <= p_wdata;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Response next-state
    // -----------------------------------------------------------------------------------------
    logic [63:0] noc_rdata_d, noc_rdata_q;
    logic        noc_error_d, noc_error_q;
    logic [31:0] p_rdata_d,   p_rdata_q;
    logic        p_error_d,   p_error_q;

    // NoC response: reads return enabled halves, disabled halves read as zero.
    always_comb begin
        noc_rdata_d = noc_rdata_q;
        noc_error_d = 1'b0;
        if (noc_acc) begin
            if (noc_oor) begin
                noc_rdata_d = '0;
                noc_error_d = 1'b1;
            end else if (spm_wr) begin
                noc_rdata_d = '0;
            end else begin
                noc_rdata_d[63:32] = spm_en[1] ? mem_hi[noc_idx] : 32'h0;
                noc_rdata_d[31:0]  = spm_en[0] ? mem_lo[noc_idx] : 32'h0;
            end
        end
    end

    // Processor response: writes (accepted or dropped) answer with zero data.
    always_comb begin
        p_rdata_d = p_rdata_q;
        p_error_d = 1'b0;
        if (p_en) begin
            if (p_oor) begin
                p_rdata_d = '0;
                p_error_d = 1'b1;
            end else if (p_wr) begin
                p_rdata_d = '0;
                p_error_d = p_collide;
            end else begin
                p_rdata_d = p_half ? mem_hi[p_idx] : mem_lo[p_idx];
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Response registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            noc_rdata_q <= '0;
            noc_error_q <= 1'b0;
            p_rdata_q   <= '0;
            p_error_q   <= 1'b0;
        end else begin
            noc_rdata_q <= noc_rdata_d;
            noc_error_q <= noc_error_d;
            p_rdata_q   <= p_rdata_d;
            p_error_q   <= p_error_d;
        end
    end

    assign spm_slv_rdata = noc_rdata_q;
    assign spm_slv_error = noc_error_q;
    assign p_rdata       = p_rdata_q;
    assign p_error       = p_error_q;

endmodule

// File: tb/tb_spm_responder.sv
module tb_spm_responder;

    localparam int unsigned AW    = 14;
    localparam int unsigned WORDS = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] spm_addr;
    logic [1:0]    spm_en;
    logic          spm_wr;
    logic [63:0]   spm_wdata;
    logic [63:0]   spm_slv_rdata;
    logic          spm_slv_error;
    logic [AW:0]   p_addr;
    logic          p_en;
    logic          p_wr;
    logic [31:0]   p_wdata;
    logic [31:0]   p_rdata;
    logic          p_error;

    always #5 clk = ~clk;

    spm_responder #(
        .ADDR_W   (AW),
        .SPM_WORDS(WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .spm_addr     (spm_addr),
        .spm_en       (spm_en),
        .spm_wr       (spm_wr),
        .spm_wdata    (spm_wdata),
        .spm_slv_rdata(spm_slv_rdata),
        .spm_slv_error(spm_slv_error),
        .p_addr       (p_addr),
        .p_en         (p_en),
        .p_wr         (p_wr),
        .p_wdata      (p_wdata),
        .p_rdata      (p_rdata),
        .p_error      (p_error)
    );

    typedef struct {
        logic [63:0] rd;
        logic        err;
    } noc_rsp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } p_rsp_t;

    noc_rsp_t noc_q[$];
    p_rsp_t   p_q[$];

    // Reference memory and last-response state
    logic [31:0] m_lo [WORDS];
    logic [31:0] m_hi [WORDS];
    logic [63:0] last_noc_rd = '0;
    logic [31:0] last_p_rd   = '0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: expected responses are pushed when driven, popped after the edge.
    task automatic step(input string tag, input logic rst,
                        input logic [AW-1:0] a, input logic [1:0] en, input logic wr,
                        input logic [63:0] wd,
                        input logic [AW:0] pa, input logic pe, input logic pw,
                        input logic [31:0] pwd);
        noc_rsp_t   ne;
        p_rsp_t     pex;
        noc_rsp_t   ng;
        p_rsp_t     pg;
        logic       noc_acc, noc_oor, p_oor, p_h, collide;
        logic [AW-1:0] pword;

        reset = rst; spm_addr = a; spm_en = en; spm_wr = wr; spm_wdata = wd;
        p_addr = pa; p_en = pe; p_wr = pw; p_wdata = pwd;

        noc_acc = |en;
        noc_oor = (32'(a) >= WORDS);
        pword   = pa[AW:1];
        p_h     = pa[0];
        p_oor   = (32'(pword) >= WORDS);
        collide = noc_acc && !noc_oor && wr && en[p_h] && (a == pword) && pe && pw && !p_oor;

        if (rst) begin
            ne.rd = '0; ne.err = 1'b0;
            pex.rd = '0; pex.err = 1'b0;
        end else begin
            ne.rd = last_noc_rd; ne.err = 1'b0;
            if (noc_acc) begin
                if (noc_oor) begin
                    ne.rd = '0; ne.err = 1'b1;
                end else if (wr) begin
                    ne.rd = '0;
                end else begin
                    ne.rd[63:32] = en[1] ? m_hi[a[9:0]] : 32'h0;
                    ne.rd[31:0]  = en[0] ? m_lo[a[9:0]] : 32'h0;
                end
            end
            pex.rd = last_p_rd; pex.err = 1'b0;
            if (pe) begin
                if (p_oor) begin
                    pex.rd = '0; pex.err = 1'b1;
                end else if (pw) begin
                    pex.rd = '0; pex.err = collide;
                end else begin
                    pex.rd = p_h ? m_hi[pword[9:0]] : m_lo[pword[9:0]];
                end
            end
            // Model update after the reads so same-cycle reads see old contents
            if (noc_acc && wr && !noc_oor) begin
                if (en[0]) m_lo[a[9:0]] = wd[31:0];
                if (en[1]) m_hi[a[9:0]] = wd[63:32];
            end
            if (pe && pw && !p_oor && !collide) begin
                if (p_h) m_hi[pword[9:0]] = pwd;
                else     m_lo[pword[9:0]] = pwd;
            end
        end
        last_noc_rd = ne.rd;
        last_p_rd   = pex.rd;
        noc_q.push_back(ne);
        p_q.push_back(pex);

        @(posedge clk);
        #1;
        ng = noc_q.pop_front();
        pg = p_q.pop_front();
        check({tag, "_noc_rd"}, spm_slv_rdata, ng.rd);
        check({tag, "_noc_err"}, 64'(spm_slv_error), 64'(ng.err));
        check({tag, "_p_rd"}, 64'(p_rdata), 64'(pg.rd));
        check({tag, "_p_err"}, 64'(p_error), 64'(pg.err));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        reset = 1'b1; spm_addr = '0; spm_en = '0; spm_wr = 1'b0; spm_wdata = '0;
        p_addr = '0; p_en = 1'b0; p_wr = 1'b0; p_wdata = '0;
        #1;

        // 1: reset with a write presented; outputs zero, write ignored
        step("rst0", 1'b1, 14'd2, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 15'd4, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step("rst1", 1'b1, 14'd2, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 15'd4, 1'b1, 1'b1, 32'hFFFF_FFFF);
        check("rst_noc_rd_zero", spm_slv_rdata, 64'h0);
        check("rst_p_rd_zero", 64'(p_rdata), 64'h0);
        step("w2", 1'b0, 14'd2, 2'b11, 1'b1, 64'h0123_4567_89AB_CDEF, '0, 1'b0, 1'b0, '0);
        step("rst2", 1'b1, 14'd2, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 15'd5, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step("r2", 1'b0, 14'd2, 2'b11, 1'b0, '0, 15'd5, 1'b1, 1'b0, '0);
        check("rst_word_kept", spm_slv_rdata, 64'h0123_4567_89AB_CDEF);
        check("rst_p_word_kept", 64'(p_rdata), 64'h0123_4567);

        // 2: NoC write then low-half read
        step("t2w", 1'b0, 14'd5, 2'b11, 1'b1, 64'hDEAD_BEEF_0123_4567, '0, 1'b0, 1'b0, '0);
        check("t2_wr_rd_zero", spm_slv_rdata, 64'h0);
        step("t2r", 1'b0, 14'd5, 2'b01, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("t2_rd_low", spm_slv_rdata, 64'h0000_0000_0123_4567);

        // 3: processor writes upper half of word 5
        step("t3w", 1'b0, '0, 2'b00, 1'b0, '0, 15'd11, 1'b1, 1'b1, 32'hCAFE_F00D);
        step("t3r", 1'b0, 14'd5, 2'b11, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("t3_rd", spm_slv_rdata, 64'hCAFE_F00D_0123_4567);
        idle("t3_hold");
        check("t3_hold_rd", spm_slv_rdata, 64'hCAFE_F00D_0123_4567);

        // 4: NoC range error, one-cycle pulse; processor served alongside
        step("t4", 1'b0, 14'(WORDS), 2'b11, 1'b0, '0, 15'd10, 1'b1, 1'b0, '0);
        check("t4_err", 64'(spm_slv_error), 64'h1);
        check("t4_p_rd", 64'(p_rdata), 64'h0123_4567);
        idle("t4_idle");
        check("t4_err_clear", 64'(spm_slv_error), 64'h0);
        step("t4w", 1'b0, 14'(WORDS), 2'b11, 1'b1, 64'h1, '0, 1'b0, 1'b0, '0);

        // Boundaries: last word on both ports, processor out of range
        step("bw", 1'b0, 14'(WORDS - 1), 2'b10, 1'b1, 64'h7777_6666_0000_0000, '0, 1'b0, 1'b0, '0);
        step("br", 1'b0, '0, 2'b00, 1'b0, '0, 15'(2 * WORDS - 1), 1'b1, 1'b0, '0);
        check("b_p_last", 64'(p_rdata), 64'h7777_6666);
        step("boor", 1'b0, '0, 2'b00, 1'b0, '0, 15'(2 * WORDS), 1'b1, 1'b1, 32'h1234);
        check("b_p_err", 64'(p_error), 64'h1);

        // 5: write collision on the same half; NoC wins
        step("t5", 1'b0, 14'd7, 2'b01, 1'b1, 64'h0000_0000_1111_1111, 15'd14, 1'b1, 1'b1, 32'h2222_2222);
        check("t5_p_err", 64'(p_error), 64'h1);
        step("t5r", 1'b0, 14'd7, 2'b01, 1'b0, '0, 15'd14, 1'b1, 1'b0, '0);
        check("t5_rd", spm_slv_rdata, 64'h0000_0000_1111_1111);

        // Different halves of the same word in the same cycle
        step("dh", 1'b0, 14'd8, 2'b01, 1'b1, 64'h0000_0000_3333_3333, 15'd17, 1'b1, 1'b1, 32'h4444_4444);
        check("dh_no_err", 64'(p_error), 64'h0);
        step("dhr", 1'b0, 14'd8, 2'b11, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("dh_rd", spm_slv_rdata, 64'h4444_4444_3333_3333);

        // 6: read-before-write across ports
        step("t6p", 1'b0, 14'd3, 2'b11, 1'b1, 64'h5555_5555_1234_5678, '0, 1'b0, 1'b0, '0);
        step("t6", 1'b0, 14'd3, 2'b11, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 15'd6, 1'b1, 1'b0, '0);
        check("t6_old", 64'(p_rdata), 64'h1234_5678);
        step("t6n", 1'b0, '0, 2'b00, 1'b0, '0, 15'd6, 1'b1, 1'b0, '0);
        check("t6_new", 64'(p_rdata), 64'hAAAA_AAAA);

        // Both ports reading the same half; then processor write vs NoC read
        step("rr", 1'b0, 14'd3, 2'b11, 1'b0, '0, 15'd7, 1'b1, 1'b0, '0);
        step("wr", 1'b0, 14'd8, 2'b10, 1'b0, '0, 15'd17, 1'b1, 1'b1, 32'h9999_0000);
        check("wr_old", spm_slv_rdata, 64'h4444_4444_0000_0000);
        step("wrn", 1'b0, 14'd8, 2'b10, 1'b0, '0, '0, 1'b0, 1'b0, '0);

        // Reset mid-run clears held responses
        step("rst3", 1'b1, '0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
